// File: rtl/sm3_pkg.sv
// SM3 shared definitions: block/digest widths, initial value, round constants,
// FSM state type and the per-round / message-expansion helper functions used
// by every lane. No ports (package).
package sm3_pkg;

  localparam int BLK_W = 512;
  localparam int DIG_W = 256;

  localparam logic [DIG_W-1:0] IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  localparam logic [31:0] T0 = 32'h79cc4519;
  localparam logic [31:0] T1 = 32'h7a879d8a;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  // Rotate left; the doubled word makes every amount 0..31 a plain slice.
  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] ff_j(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic [5:0] j);
    return (j < 6'd16) ? (x ^ y ^ z) : ((x & y) | (x & z) | (y & z));
  endfunction

  function automatic logic [31:0] gg_j(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic [5:0] j);
    return (j < 6'd16) ? (x ^ y ^ z) : ((x & y) | (~x & z));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol32(x, 5'd9) ^ rol32(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol32(x, 5'd15) ^ rol32(x, 5'd23);
  endfunction

  // W_j from its five predecessors (named by their distance back from j).
  function automatic logic [31:0] w_expand(input logic [31:0] w16, input logic [31:0] w9,
                                           input logic [31:0] w3, input logic [31:0] w13,
                                           input logic [31:0] w6);
    return p1(w16 ^ w9 ^ rol32(w3, 5'd15)) ^ rol32(w13, 5'd7) ^ w6;
  endfunction

  // One compression round on the packed {A..H} state (A in the MSBs).
  function automatic logic [DIG_W-1:0] sm3_round(input logic [DIG_W-1:0] v, input logic [5:0] j,
                                                 input logic [31:0] w, input logic [31:0] wp);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] a12, tj, ss1, ss2, tt1, tt2;
    {a, b, c, d, e, f, g, h} = v;
    tj  = rol32((j < 6'd16) ? T0 : T1, j[4:0]);
    a12 = rol32(a, 5'd12);
    ss1 = rol32(a12 + e + tj, 5'd7);
    ss2 = ss1 ^ a12;
    tt1 = ff_j(a, b, c, j) + d + ss2 + wp;
    tt2 = gg_j(e, f, g, j) + h + ss1 + w;
    return {tt1, a, rol32(b, 5'd9), c, p0(tt2), e, rol32(f, 5'd19), g};
  endfunction

endpackage

// File: rtl/sm3_lane.sv
// One SM3 compression lane.
// Ports:
//   clk    - clock
//   load   - capture v_load as V_in and {A..H}, and blk into the W window
//   step   - perform RPC rounds starting at round index 'round'
//   round  - index j of the first round in this step
//   v_load - starting chain value (IV or previous digest)
//   blk    - 512-bit message block, word 0 in the MSBs
//   digest - V_in ^ {A..H}; the final digest once all 64 rounds are done
module sm3_lane
  import sm3_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [5:0]       round,
  input  logic [DIG_W-1:0] v_load,
  input  logic [BLK_W-1:0] blk,
  output logic [DIG_W-1:0] digest
);

  // w_reg[0] is W_j for the current round; the window holds W_j..W_j+15,
  // which covers the W_j+4 lookahead for every round in a step (RPC <= 4).
  logic [31:0]      w_reg [16];
  logic [31:0]      ext   [16+RPC];
  logic [DIG_W-1:0] v_in_reg;
  logic [DIG_W-1:0] st_reg;
  logic [DIG_W-1:0] st_next;

  always_comb begin
    st_next = st_reg;
    for (int i = 0; i < 16; i++) begin
      ext[i] = w_reg[i];
    end
    // Later new words may depend on earlier new words of the same step.
    for (int k = 0; k < RPC; k++) begin
      ext[16+k] = w_expand(ext[k], ext[k+7], ext[k+13], ext[k+3], ext[k+10]);
    end
    for (int k = 0; k < RPC; k++) begin
      st_next = sm3_round(st_next, round + 6'(k), ext[k], ext[k] ^ ext[k+4]);
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      v_in_reg <= v_load;
      st_reg   <= v_load;
      for (int i = 0; i < 16; i++) begin
        w_reg[i] <= blk[BLK_W-1-32*i -: 32];
      end
    end else if (step) begin
      st_reg <= st_next;
      for (int i = 0; i < 16; i++) begin
        w_reg[i] <= ext[i+RPC];
      end
    end
  end

  assign digest = v_in_reg ^ st_reg;

endmodule

// File: rtl/sm3_multilane_engine.sv
// Multi-lane SM3 compression engine: LANES independent lanes under one
// controller, RPC rounds per clock.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   start    - job request, honoured only while ready=1
//   first    - 1: lanes start from the IV; 0: lanes chain from their dout slice
//   lane_en  - per-lane enable, captured with start
//   din      - lane i block at din[i*512 +: 512]
//   ready    - a start this cycle would be accepted
//   valid    - one-cycle pulse: dout changed at the preceding edge
//   dout     - lane i digest at dout[i*256 +: 256], A word in the MSBs
module sm3_multilane_engine
  import sm3_pkg::*;
#(
  parameter int LANES = 4,
  parameter int RPC   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   first,
  input  logic [LANES-1:0]       lane_en,
  input  logic [LANES*BLK_W-1:0] din,
  output logic                   ready,
  output logic                   valid,
  output logic [LANES*DIG_W-1:0] dout
);

  if (RPC != 1 && RPC != 2 && RPC != 4) begin : g_bad_rpc
    $error("sm3_multilane_engine: RPC must be 1, 2 or 4");
  end
  if (LANES < 1 || LANES > 8) begin : g_bad_lanes
    $error("sm3_multilane_engine: LANES must be 1..8");
  end

  localparam logic [5:0] LAST_CNT = 6'(64 - RPC);

  state_t                 state_reg, state_next;
  logic [5:0]             cnt_reg;
  logic [LANES-1:0]       en_reg;
  logic                   valid_reg;
  logic [LANES*DIG_W-1:0] dout_reg;
  logic [LANES*DIG_W-1:0] dout_next;
  logic [LANES*DIG_W-1:0] digest_w;
  logic [LANES*DIG_W-1:0] v_load_w;
  logic                   accept;
  logic                   run;
  logic                   fin;

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_reg == LAST_CNT) state_next = ST_FIN;
      end
      ST_FIN: begin
        ready      = 1'b1;
        state_next = start ? ST_RUN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign accept = start && ready;
  assign run    = (state_reg == ST_RUN);
  assign fin    = (state_reg == ST_FIN);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign dout_next[gi*DIG_W +: DIG_W] = (fin && en_reg[gi]) ? digest_w[gi*DIG_W +: DIG_W]
                                                              : dout_reg[gi*DIG_W +: DIG_W];
    // Chaining reads dout_next so a back-to-back job sees the digest written this edge.
    assign v_load_w[gi*DIG_W +: DIG_W] = first ? IV : dout_next[gi*DIG_W +: DIG_W];

    sm3_lane #(
      .RPC(RPC)
    ) u_lane (
      .clk   (clk),
      .load  (accept),
      .step  (run),
      .round (cnt_reg),
      .v_load(v_load_w[gi*DIG_W +: DIG_W]),
      .blk   (din[gi*BLK_W +: BLK_W]),
      .digest(digest_w[gi*DIG_W +: DIG_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      en_reg    <= '0;
      valid_reg <= 1'b0;
      dout_reg  <= {LANES{IV}};
    end else begin
      state_reg <= state_next;
      valid_reg <= fin;
      dout_reg  <= dout_next;
      if (accept) begin
        cnt_reg <= '0;
        en_reg  <= lane_en;
      end else if (run) begin
        cnt_reg <= cnt_reg + 6'(RPC);
      end
    end
  end

  assign valid = valid_reg;
  assign dout  = dout_reg;

endmodule

// File: tb/tb_sm3_multilane_engine.sv
module tb_sm3_multilane_engine;

  localparam logic [255:0] IV_C =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [255:0] ABC_D =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] CHAIN_D =
    256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
  localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_ABCD = {16{32'h61626364}};
  localparam logic [511:0] BLK_PAD2 = {32'h80000000, 448'h0, 32'h00000200};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, first = 1'b1;
  logic [3:0]    lane_en = 4'hf;
  logic [2047:0] din = '0;
  logic          ready, valid;
  logic [1023:0] dout;
  logic          start2 = 1'b0, first2 = 1'b1;
  logic [1:0]    lane_en2 = 2'b11;
  logic [1023:0] din2 = '0;
  logic          ready2, valid2;
  logic [511:0]  dout2;

  int n_vec = 0;
  int n_bad = 0;
  int n, n2;

  always #5 clk = ~clk;

  sm3_multilane_engine #(.LANES(4), .RPC(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .first(first), .lane_en(lane_en),
    .din(din), .ready(ready), .valid(valid), .dout(dout)
  );

  sm3_multilane_engine #(.LANES(2), .RPC(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start2), .first(first2), .lane_en(lane_en2),
    .din(din2), .ready(ready2), .valid(valid2), .dout(dout2)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %h expected %h", n_vec, tag, obs, exp);
  endtask

  task automatic chk_lanes(input string tag, input logic [3:0] mask_abc,
                           input logic [255:0] dig, input logic [255:0] other);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_lane%0d", tag, i), dout[i*256 +: 256], mask_abc[i] ? dig : other);
  endtask

  task automatic chk_lanes2(input string tag, input logic [255:0] dig);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_lane%0d", tag, i), dout2[i*256 +: 256], dig);
  endtask

  task automatic pulse(input bit which);
    @(negedge clk);
    if (which) start2 = 1'b1;
    else start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // Counts edges until valid is seen (sampled 1 unit after each edge), bounded.
  task automatic wait_valid(input bit which, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!(which ? valid2 : valid) && cnt < 300);
  endtask

  task automatic count_valids(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (valid) c++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_ready", 256'(ready), 256'd1);
    chk("rst_valid", 256'(valid), 256'd0);
    chk_lanes("rst_dout", 4'h0, ABC_D, IV_C);
    chk("rst_ready2", 256'(ready2), 256'd1);

    // 1: "abc" on all lanes
    din = {4{BLK_ABC}}; first = 1'b1; lane_en = 4'hf;
    pulse(0);
    wait_valid(0, n);
    chk("t1_latency", 256'(n), 256'd65);
    chk_lanes("t1_dig", 4'hf, ABC_D, IV_C);
    @(posedge clk); #1;
    chk("t1_valid_pulse", 256'(valid), 256'd0);
    chk("t1_ready", 256'(ready), 256'd1);

    // 2: two-block chain
    din = {4{BLK_ABCD}}; first = 1'b1;
    pulse(0);
    wait_valid(0, n);
    chk("t2_latency_a", 256'(n), 256'd65);
    din = {4{BLK_PAD2}}; first = 1'b0;
    pulse(0);
    wait_valid(0, n);
    chk("t2_latency_b", 256'(n), 256'd65);
    chk_lanes("t2_dig", 4'hf, CHAIN_D, IV_C);

    // 3: partial lane enable after reset
    do_reset();
    din = {4{BLK_ABC}}; first = 1'b1; lane_en = 4'b0101;
    pulse(0);
    wait_valid(0, n);
    chk("t3_latency", 256'(n), 256'd65);
    chk_lanes("t3_dig", 4'b0101, ABC_D, IV_C);
    count_valids(70, n2);
    chk("t3_extra_valids", 256'(n2), 256'd0);

    // 4a: start pulsed mid-run is ignored
    lane_en = 4'hf; din = {4{BLK_ABC}}; first = 1'b1;
    pulse(0);
    repeat (20) @(posedge clk);
    #1;
    din = {4{BLK_ABCD}}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(0, n);
    chk("t4_latency", 256'(n + 21), 256'd65);
    chk_lanes("t4_dig", 4'hf, ABC_D, IV_C);
    count_valids(70, n2);
    chk("t4_extra_valids", 256'(n2), 256'd0);

    // 4b: start held through FIN gives a back-to-back chained job
    din = {4{BLK_ABCD}}; first = 1'b1;
    pulse(0);
    repeat (10) @(posedge clk);
    #1;
    din = {4{BLK_PAD2}}; first = 1'b0; start = 1'b1;
    wait_valid(0, n);
    start = 1'b0;
    chk("t4_b2b_first", 256'(n + 10), 256'd65);
    chk("t4_b2b_busy", 256'(ready), 256'd0);
    wait_valid(0, n);
    chk("t4_b2b_second", 256'(n), 256'd65);
    chk_lanes("t4_b2b_dig", 4'hf, CHAIN_D, IV_C);

    // 5: reset aborts a running job
    din = {4{BLK_ABC}}; first = 1'b1;
    pulse(0);
    repeat (29) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_ready", 256'(ready), 256'd1);
    chk("t5_valid", 256'(valid), 256'd0);
    chk_lanes("t5_dout", 4'h0, ABC_D, IV_C);
    @(negedge clk);
    rst = 1'b0;
    count_valids(80, n2);
    chk("t5_no_valid", 256'(n2), 256'd0);
    first = 1'b0;
    pulse(0);
    wait_valid(0, n);
    chk("t5_latency", 256'(n), 256'd65);
    chk_lanes("t5_dig", 4'hf, ABC_D, IV_C);

    // 6: LANES=2, RPC=4
    din2 = {2{BLK_ABC}}; first2 = 1'b1; lane_en2 = 2'b11;
    pulse(1);
    wait_valid(1, n);
    chk("t6_latency_abc", 256'(n), 256'd17);
    chk_lanes2("t6_abc", ABC_D);
    din2 = {2{BLK_ABCD}};
    pulse(1);
    wait_valid(1, n);
    chk("t6_latency_a", 256'(n), 256'd17);
    din2 = {2{BLK_PAD2}}; first2 = 1'b0;
    pulse(1);
    wait_valid(1, n);
    chk("t6_latency_b", 256'(n), 256'd17);
    chk_lanes2("t6_chain", CHAIN_D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
